// File: rtl/logic_alu_seq.sv
// Registered logic/arithmetic unit: bitwise ops, ADD and an iterative left
// shift. Valid/ready on both sides, one result slot, optional accumulator
// feedback as operand A.
module logic_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       sel,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_work;
    logic [SW-1:0]    r_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [SW-1:0]    w_n;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_op_res;
    logic             w_op_carry;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load_carry;
    logic             w_start_shift;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign busy      = (r_state == S_SHIFT);
    assign out       = r_out;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign out_valid = r_out_valid;

    assign w_accept = in_valid && in_ready;
    assign w_a      = acc_mode ? r_acc : a_in;
    assign w_n      = b_in[SW-1:0];
    assign w_sum    = {1'b0, w_a} + {1'b0, b_in};

    // Single-cycle result for every opcode except a nonzero shift
    always_comb begin
        w_op_res   = '0;
        w_op_carry = 1'b0;
        case (sel)
            OP_AND:  w_op_res = w_a & b_in;
            OP_OR:   w_op_res = w_a | b_in;
            OP_XOR:  w_op_res = w_a ^ b_in;
            OP_NAND: w_op_res = ~(w_a & b_in);
            OP_NOR:  w_op_res = ~(w_a | b_in);
            OP_XNOR: w_op_res = ~(w_a ^ b_in);
            OP_ADD: begin
                w_op_res   = w_sum[WIDTH-1:0];
                w_op_carry = w_sum[WIDTH];
            end
            default: w_op_res = w_a;  // SHL by 0 passes A through
        endcase
    end

    // Next state and result-slot load decision
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_load_carry  = 1'b0;
        w_start_shift = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((sel == OP_SHL) && (w_n != '0)) begin
                        w_start_shift = 1'b1;
                        w_state_nxt   = S_SHIFT;
                    end else begin
                        w_load       = 1'b1;
                        w_load_val   = w_op_res;
                        w_load_carry = w_op_carry;
                    end
                end
            end
            S_SHIFT: begin
                if (r_count == SW'(1)) begin
                    // final shift goes straight into the result slot
                    w_load       = 1'b1;
                    w_load_val   = {r_work[WIDTH-2:0], 1'b0};
                    w_load_carry = r_work[WIDTH-1];
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift work register and remaining-count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
        end else if (w_start_shift) begin
            r_work  <= w_a;
            r_count <= w_n;
        end else if (r_state == S_SHIFT) begin
            r_work  <= {r_work[WIDTH-2:0], 1'b0};
            r_count <= SW'(r_count - SW'(1));
        end
    end

    // Result slot and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_zero      <= 1'b1;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_out   <= w_load_val;
                r_zero  <= (w_load_val == '0);
                r_carry <= w_load_carry;
                r_acc   <= w_load_val;
            end
            r_out_valid <= w_load || (r_out_valid && !out_ready);
        end
    end

endmodule

// File: doc/logic_alu_seq.md
# logic_alu_seq

Parametrised, registered successor to the 2-bit combinational logic unit. It has a WIDTH-bit datapath and the same 3-bit `sel` opcode space, extended with ADD and an iterative multi-cycle shift. Valid/ready handshakes sit on both input and output. An accumulate mode feeds the previous result back as operand A. It sits between an operand source and a result consumer in the ALU datapath, with one result slot of buffering.

## Interface
- `WIDTH`, 8, datapath width (≥2).
- `SW`, $clog2(WIDTH), width of the shift-amount field taken from `b_in`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand/opcode presented.
- `in_ready`  out  1  block can accept this cycle.
- `a_in`  in  WIDTH  operand A (ignored when `acc_mode`=1).
- `b_in`  in  WIDTH  operand B; for SHL, `b_in[SW-1:0]` is the shift amount N.
- `sel`  in  3  opcode.
- `acc_mode`  in  1  when 1, operand A = accumulator register.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  WIDTH  result.
- `zero`  out  1  `out`==0.
- `carry`  out  1  ADD carry-out / last bit shifted out by SHL; 0 for logic ops.
- `busy`  out  1  FSM in SHIFT.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR: bitwise on the WIDTH-bit operands.
  - 110 ADD: A+B mod 2^WIDTH, carry = bit WIDTH of the sum.
  - 111 SHL: logical left shift of A by N, one bit per cycle, zero fill.
- `sel` with X/Z is unsupported; no detection is required.
- Accumulator: a WIDTH-bit register that loads the same value as `out` whenever the result slot loads. It is read as A when `acc_mode`=1, with `acc_mode` sampled at accept.
- FSM states:
  - IDLE → SHIFT on accept of SHL with N>0.
  - SHIFT → IDLE on the edge that performs the N-th shift.
  - Every other accept stays in IDLE.
- SHIFT state: each cycle, the work register shifts left by 1, `carry_work` takes the old MSB, and `count` decrements. On the edge where `count`==1, the shifted value and the bit shifted out load the result slot.
- SHL with N=0 completes like a logic op: `out`=A, `carry`=0.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- `busy` = (state==SHIFT).
- `out`, `zero`, `carry` change only when the result slot loads. While `out_valid`=1 and `out_ready`=0 they stay stable.
- `out_valid` sets when the slot loads. It clears on an output handshake with no simultaneous load.
- A simultaneous output handshake and new load leaves `out_valid`=1 with the new data.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `out`=0, `acc`=0, `out_valid`=0, `carry`=0, `zero`=1, `busy`=0, `in_ready`=1.
- Accept happens on the edge of cycle k where `in_valid` && `in_ready`.
- Logic ops, ADD, and SHL with N=0: `out_valid`=1 in cycle k+1.
  - Back-to-back issue is allowed at 1 op/cycle while `out_ready`=1.
- SHL with N>0: `busy`=1 and `in_ready`=0 in cycles k+1..k+N; `out_valid`=1 in cycle k+N+1.
  - The result slot is necessarily empty at completion, because accept required a free or draining slot.
- Inputs `a_in`, `b_in`, `sel`, `acc_mode` are sampled only at accept and may change freely afterwards.
- Reset asserted mid-SHIFT aborts the operation immediately. No result is produced and all registers return to reset values.
- Accumulator update and the `out` update happen on the same edge. The next accept with `acc_mode`=1 (earliest cycle k+1) uses the new value.

## Test plan
- Reset check: hold `rst_n`=0 → `out`=0, `zero`=1, `out_valid`=0, `in_ready`=1, `busy`=0. Then, with `a_in`=0xF0, `b_in`=0x3C and `out_ready`=1, sweep `sel` 000..101 one per cycle → `out` = 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, each in the cycle after its accept.
- ADD: A=0xFF, B=0x01, `sel`=110 → `out`=0x00, `carry`=1, `zero`=1. Then A=0x12, B=0x34 → `out`=0x46, `carry`=0, `zero`=0.
- SHL, N=3: A=0xB1, B=0x03 → `busy` high 3 cycles, `in_ready` low 3 cycles, `out`=0x88, `carry`=1, `out_valid` in cycle k+4.
- SHL, N=0: A=0xB1, B=0x00 → `out`=0xB1, `carry`=0 in cycle k+1.
- Backpressure: `out_ready`=0 after a result → `in_ready`=0 and `out` stable for 5 cycles. Raising `out_ready` together with a new `in_valid` → handshake and accept in the same cycle, and the new result appears next cycle with no bubble.
- Accumulate: ADD A=0x05, B=0x03 → 0x08; then `acc_mode`=1, ADD B=0x10 → 0x18; then `acc_mode`=1, XOR B=0xFF → 0xE7. Separately, pulse `rst_n` low at cycle k+2 of an SHL with N=6 → no `out_valid`, and all outputs at reset values.
